// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the two-port SRAM arbiter.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  typedef logic owner_t;

  localparam int DEF_DATA_WIDTH = 3;
  localparam int DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last owner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstb,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant_o = valid_i;
    // On a tie, the requester that did not win last time goes first.
    if (valid_i == 2'b11) begin
      grant_o = ptr_q ? 2'b01 : 2'b10;
    end
    ptr_d = ptr_q;
    if (accept_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between two requesters; drives the macro
// pins from registers and returns each read to the port that issued it.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  state_e                  state_q, state_d;
  owner_t                  owner_q;
  logic [1:0]              grant;
  logic                    accept;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    csb_q, web_q, oeb_q, drv_q;
  logic [1:0]              rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;

  rr_arb2 u_arb (
    .clk      (clk),
    .rstb     (rstb),
    .valid_i  ({req1_valid, req0_valid}),
    .accept_i (state_q == ST_IDLE),
    .grant_o  (grant)
  );

  assign accept     = (state_q == ST_IDLE) && (grant != 2'b00);
  assign req0_ready = (state_q == ST_IDLE) && grant[0];
  assign req1_ready = (state_q == ST_IDLE) && grant[1];

  assign sel_we    = grant[1] ? req1_we    : req0_we;
  assign sel_addr  = grant[1] ? req1_addr  : req0_addr;
  assign sel_wdata = grant[1] ? req1_wdata : req0_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = sel_we ? ST_WRITE : ST_READ;
      ST_WRITE:   state_d = ST_IDLE;
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      drv_q       <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      csb_q       <= (state_d == ST_IDLE);
      web_q       <= (state_d != ST_WRITE);
      oeb_q       <= (state_d != ST_CAPTURE);
      drv_q       <= (state_d == ST_WRITE);
      rsp_valid_q <= 2'b00;
      if (accept) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        owner_q <= grant[1];
      end
      if (state_q == ST_CAPTURE) begin
        rsp_valid_q[owner_q] <= 1'b1;
        if (owner_q) rdata1_q <= sram_data;
        else         rdata0_q <= sram_data;
      end
    end
  end

  assign sram_data  = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign sram_addr  = addr_q;
  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_oeb   = oeb_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM on the pins.
module tb_sram_port_arbiter;

  logic       clk = 1'b0;
  logic       rstb;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [3:0] req0_addr, req1_addr;
  logic [2:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [2:0] rsp0_rdata, rsp1_rdata;
  logic [3:0] sram_addr;
  logic       sram_csb, sram_web, sram_oeb;
  wire  [2:0] sram_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.DATA_WIDTH(3), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rstb(rstb),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_addr(sram_addr), .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_oeb(sram_oeb), .sram_data(sram_data)
  );

  // Behavioural OpenRAM-style macro: synchronous write/read, OEb-gated output.
  logic [2:0] mem [16];
  logic [2:0] mdout_q;
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_data;
      else           mdout_q <= mem[sram_addr];
    end
  end
  assign sram_data = (!sram_csb && !sram_oeb) ? mdout_q : 3'bzzz;

  // Advance one cycle; while the macro drives DATA, confirm the DUT does not.
  task automatic tick();
    @(posedge clk); #1;
    if (!sram_csb && !sram_oeb) begin
      n_assert++;
      if (dut.drv_q !== 1'b0 || sram_web !== 1'b1) begin
        n_fail++;
        $display("FAIL contention: drv=%b web=%b, required drv=0 web=1", dut.drv_q, sram_web);
      end
      n_assert++;
      if (sram_data !== mdout_q) begin
        n_fail++;
        $display("FAIL capture_bus: data=%b, required %b", sram_data, mdout_q);
      end
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
  endtask

  task automatic apply_reset();
    rstb = 0;
    tick(); tick();
    rstb = 1;
  endtask

  task automatic do_write(input int port, input logic [3:0] a, input logic [2:0] d);
    bit got = 0;
    if (port == 0) begin req0_valid = 1; req0_we = 1; req0_addr = a; req0_wdata = d; end
    else           begin req1_valid = 1; req1_we = 1; req1_addr = a; req1_wdata = d; end
    #1;
    for (int k = 0; k < 8 && !got; k++) begin
      if ((port == 0) ? req0_ready : req1_ready) got = 1;
      else tick();
    end
    if (!got) begin
      n_assert++; n_fail++;
      $display("FAIL write_accept_timeout: port=%0d never ready, required ready within 8 cycles", port);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    apply_reset();
    n_assert++;
    if ({sram_csb, sram_web, sram_oeb} !== 3'b111) begin
      n_fail++; $display("FAIL reset_pins: csb/web/oeb=%b, required 111", {sram_csb, sram_web, sram_oeb});
    end
    n_assert++;
    if (dut.drv_q !== 1'b0 || sram_addr !== 4'h0) begin
      n_fail++; $display("FAIL reset_bus: drv=%b addr=%h, required drv=0 addr=0", dut.drv_q, sram_addr);
    end
    n_assert++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000 ||
        rsp0_rdata !== 3'b000 || rsp1_rdata !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: rdy=%b%b rsp=%b%b rdata=%b/%b, required all 0",
                         req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata);
    end
  endtask

  task automatic test_single_write_read();
    req0_valid = 1; req0_we = 1; req0_addr = 4'h5; req0_wdata = 3'b101;
    #1;
    n_assert++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL wr_ready: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0;
    n_assert++;
    if ({sram_csb, sram_web, sram_oeb} !== 3'b001 || sram_addr !== 4'h5 ||
        sram_data !== 3'b101 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL write_phase: pins=%b addr=%h data=%b rdy=%b, required 001 5 101 0",
                         {sram_csb, sram_web, sram_oeb}, sram_addr, sram_data, req0_ready);
    end
    tick();
    n_assert++;
    if (mem[5] !== 3'b101) begin
      n_fail++; $display("FAIL write_commit: mem[5]=%b, required 101", mem[5]);
    end
    req0_valid = 1; req0_we = 0; req0_addr = 4'h5;
    #1;
    n_assert++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_ready: rdy0=%b, required 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    n_assert++;
    if ({sram_csb, sram_web, sram_oeb} !== 3'b011 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL read_phase: pins=%b rdy=%b, required 011 0", {sram_csb, sram_web, sram_oeb}, req0_ready);
    end
    tick();
    n_assert++;
    if ({sram_csb, sram_web, sram_oeb} !== 3'b010 || rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL capture_phase: pins=%b rsp0=%b, required 010 0", {sram_csb, sram_web, sram_oeb}, rsp0_valid);
    end
    tick();
    n_assert++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 3'b101 || rsp1_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_latency: rsp0=%b rdata=%b rsp1=%b, required 1 101 0", rsp0_valid, rsp0_rdata, rsp1_valid);
    end
    tick();
    n_assert++;
    if (rsp0_valid !== 1'b0 || {sram_csb, sram_web, sram_oeb} !== 3'b111) begin
      n_fail++; $display("FAIL rsp_pulse: rsp0=%b pins=%b, required 0 111", rsp0_valid, {sram_csb, sram_web, sram_oeb});
    end
  endtask

  task automatic test_tie_arbitration();
    do_write(0, 4'h1, 3'b011);
    do_write(1, 4'h2, 3'b110);
    apply_reset();
    req0_valid = 1; req0_we = 0; req0_addr = 4'h1;
    req1_valid = 1; req1_we = 0; req1_addr = 4'h2;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic exp_g;
      logic [2:0] exp_d;
      exp_g = k[0];
      exp_d = exp_g ? 3'b110 : 3'b011;
      n_assert++;
      if (req0_ready !== ~exp_g || req1_ready !== exp_g) begin
        n_fail++; $display("FAIL tie_grant[%0d]: rdy0=%b rdy1=%b, required %b %b", k, req0_ready, req1_ready, ~exp_g, exp_g);
      end
      tick(); tick(); tick();
      n_assert++;
      if (rsp0_valid !== ~exp_g || rsp1_valid !== exp_g ||
          (exp_g ? rsp1_rdata : rsp0_rdata) !== exp_d) begin
        n_fail++; $display("FAIL tie_rsp[%0d]: rsp=%b%b rdata0=%b rdata1=%b, required port %0d data %b",
                           k, rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata, exp_g, exp_d);
      end
    end
    req0_valid = 0; req1_valid = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    req1_valid = 1; req1_we = 1;
    for (int i = 0; i < 16; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      req1_addr = iv[3:0]; req1_wdata = iv[2:0];
      #1;
      n_assert++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b_accept[%0d]: rdy1=%b rdy0=%b, required 1 0", i, req1_ready, req0_ready);
      end
      tick();
      n_assert++;
      if (req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b_gap[%0d]: rdy1=%b, required 0", i, req1_ready);
      end
      tick();
    end
    req1_we = 0;
    for (int i = 0; i < 17; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      req1_addr = iv[3:0];
      tick(); tick(); tick();
      n_assert++;
      if (rsp1_valid !== 1'b1 || rsp1_rdata !== iv[2:0] || rsp0_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_read[%0d]: rsp1=%b rdata=%b rsp0=%b, required 1 %b 0",
                           i, rsp1_valid, rsp1_rdata, rsp0_valid, iv[2:0]);
      end
    end
    req1_valid = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    req0_valid = 1; req0_we = 0; req0_addr = 4'h5;
    tick();
    req0_valid = 0;
    rstb = 0;
    tick();
    rstb = 1;
    n_assert++;
    if ({sram_csb, sram_web, sram_oeb} !== 3'b111 || rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle: pins=%b rsp0=%b, required 111 0", {sram_csb, sram_web, sram_oeb}, rsp0_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_assert++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || sram_oeb !== 1'b1) begin
        n_fail++; $display("FAIL midrst_no_rsp[%0d]: rsp=%b%b oeb=%b, required 00 1", k, rsp1_valid, rsp0_valid, sram_oeb);
      end
    end
    req0_valid = 1; req0_we = 0; req0_addr = 4'h5;
    #1;
    n_assert++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready: rdy0=%b, required 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    tick(); tick();
    n_assert++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 3'b101) begin
      n_fail++; $display("FAIL midrst_reread: rsp0=%b rdata=%b, required 1 101", rsp0_valid, rsp0_rdata);
    end
  endtask

  initial begin
    rstb = 1;
    idle_inputs();
    test_reset();
    test_single_write_read();
    test_tie_arbitration();
    test_back_to_back();
    test_reset_mid_read();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
